// File: rtl/edge_arb_pkg.sv
// rtl/edge_arb_pkg.sv - shared constants, width helper and output payload type for the edge event arbiter
package edge_arb_pkg;

    localparam int DEFAULT_NUM_CH = 8;
    // Payload id is sized for the largest supported channel count (32).
    localparam int MAX_ID_W = 5;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic                pol;
    } evt_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin selector: rotate by ptr, priority-encode, unrotate
module rr_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N = DEFAULT_NUM_CH,
    localparam int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_id,
    output logic          gnt_valid
);

    localparam logic [PW:0] N_W = (PW+1)'(N);

    logic [N-1:0]  rot;
    logic [PW-1:0] off;
    logic [PW:0]   sum;

    // rot[k] = req[(ptr + k) mod N]; ptr is always below N.
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        off = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (rot[k]) begin
                off = PW'(k);
            end
        end
        gnt_valid = |rot;
        sum       = {1'b0, ptr} + {1'b0, off};
        gnt_id    = PW'((sum >= N_W) ? (sum - N_W) : sum);
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-channel edge capture, pending/overflow tracking and RR event stream
// Define EDGE_ARB_BOTH_EDGES_EN to report falling edges too, with polarity on out_pol.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    localparam int ID_W = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] evt_in,
    input  logic [NUM_CH-1:0] en_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ID_W-1:0]   out_id,
    output logic              out_pol,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] ovf,
    input  logic [NUM_CH-1:0] ovf_clr
);

    logic [NUM_CH-1:0] prev_q, pend_q, pend_d, ovf_q, ovf_d, det, load_oh;
    logic [ID_W-1:0]   ptr_q, ptr_d, gnt_id;
    logic              gnt_valid, load, out_valid_q, out_valid_d;
    logic              sel_pol;
    evt_t              evt_q, evt_d;

`ifdef EDGE_ARB_BOTH_EDGES_EN
    localparam logic POL_RST = 1'b0;
    logic [NUM_CH-1:0] pol_q, pol_d, pol_cap;

    assign det     = (evt_in ^ prev_q) & en_mask;
    // Capture polarity only for an event that becomes the new pending one.
    assign pol_cap = det & (~pend_q | load_oh);
    assign pol_d   = (pol_cap & evt_in) | (~pol_cap & pol_q);
    assign sel_pol = pol_q[gnt_id];
`else
    localparam logic POL_RST = 1'b1;

    assign det     = evt_in & ~prev_q & en_mask;
    assign sel_pol = 1'b1;
`endif

    rr_arbiter #(.N(NUM_CH)) u_rr (
        .req       (pend_q),
        .ptr       (ptr_q),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    assign load    = ~out_valid_q | out_ready;
    assign load_oh = (load && gnt_valid) ? ({{(NUM_CH-1){1'b0}}, 1'b1} << gnt_id) : '0;
    // A det on the channel being loaded re-arms pending rather than overflowing.
    assign pend_d  = (pend_q & ~load_oh) | det;
    assign ovf_d   = (ovf_q & ~ovf_clr) | (det & pend_q & ~load_oh);

    always_comb begin
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        evt_d       = evt_q;
        if (load) begin
            out_valid_d = gnt_valid;
            if (gnt_valid) begin
                evt_d.id  = MAX_ID_W'(gnt_id);
                evt_d.pol = sel_pol;
                ptr_d     = (gnt_id == ID_W'(NUM_CH-1)) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= '0;
            pend_q      <= '0;
            ovf_q       <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            evt_q       <= '{id: '0, pol: POL_RST};
`ifdef EDGE_ARB_BOTH_EDGES_EN
            pol_q       <= '0;
`endif
        end else begin
            prev_q      <= evt_in;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            evt_q       <= evt_d;
`ifdef EDGE_ARB_BOTH_EDGES_EN
            pol_q       <= pol_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = ID_W'(evt_q.id);
    assign out_pol   = evt_q.pol;
    assign pending   = pend_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - scoreboard bench for edge_event_arbiter
module tb_edge_event_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] evt_in, en_mask, ovf_clr;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_id;
    logic       out_pol;
    logic [7:0] pending, ovf;

    typedef struct packed {
        logic [2:0] id;
        logic       pol;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] stall_stim [10] = '{8'h00, 8'h82, 8'h00, 8'h82, 8'h00,
                                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    edge_event_arbiter #(.NUM_CH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .evt_in    (evt_in),
        .en_mask   (en_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_pol   (out_pol),
        .pending   (pending),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic pol);
        sb.push_back('{id: 3'(id), pol: pol});
    endtask

    task automatic do_reset;
        rst    = 1'b1;
        evt_in = '0;
        ovf_clr = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got id %0d pol %0d, required no event", out_id, out_pol);
            end else begin
                e = sb.pop_front();
                if (out_id !== e.id || out_pol !== e.pol) begin
                    n_fail++;
                    $display("FAIL event: got id %0d pol %0d, required id %0d pol %0d",
                             out_id, out_pol, e.id, e.pol);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        evt_in    = '0;
        en_mask   = 8'hFF;
        ovf_clr   = '0;
        out_ready = 1'b1;
        tick;
        chk("rst_valid", out_valid, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_id", out_id, 0);
        rst = 1'b0;

`ifdef EDGE_ARB_BOTH_EDGES_EN
        push(2, 1'b1);
        push(2, 1'b0);
        evt_in = 8'h04;
        repeat (3) tick;
        evt_in = 8'h00;
        tick;
        chk("fall_pending", pending, 8'h04);
        tick;
        chk("fall_id", out_id, 2);
        chk("fall_pol", out_pol, 0);
        repeat (3) tick;
`else
        // single rise on ch3
        push(3, 1'b1);
        evt_in = 8'h08;
        tick;
        chk("t1_pending_set", pending, 8'h08);
        tick;
        chk("t1_valid", out_valid, 1);
        chk("t1_id", out_id, 3);
        chk("t1_pending_clr", pending, 0);
        tick;
        chk("t1_valid_one_cycle", out_valid, 0);
        evt_in = 8'h00;
        tick;

        // simultaneous rises, pointer from 0; then pointer at 6 wraps to ch0 first
        do_reset;
        push(0, 1'b1); push(2, 1'b1); push(5, 1'b1);
        evt_in = 8'h25;
        tick;
        chk("t2_pending", pending, 8'h25);
        tick;
        chk("t2_id0", out_id, 0);
        tick;
        chk("t2_id2", out_id, 2);
        tick;
        chk("t2_id5", out_id, 5);
        tick;
        chk("t2_idle", out_valid, 0);
        evt_in = 8'h00;
        tick;
        push(0, 1'b1); push(5, 1'b1);
        evt_in = 8'h21;
        tick;
        tick;
        chk("t2_wrap_first", out_id, 0);
        tick;
        chk("t2_wrap_second", out_id, 5);
        tick;
        evt_in = 8'h00;
        tick;

        // stall with ch1 presented; ch1 and ch7 re-pend then overflow
        out_ready = 1'b0;
        push(1, 1'b1);
        evt_in = 8'h02;
        tick;
        tick;
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_id", out_id, 1);
            evt_in = stall_stim[i];
            tick;
        end
        chk("t3_hold_id_end", out_id, 1);
        chk("t3_pending", pending, 8'h82);
        chk("t3_ovf_set", ovf, 8'h82);
        ovf_clr = 8'h02;
        tick;
        ovf_clr = 8'h00;
        chk("t3_ovf_clr1", ovf, 8'h80);
        chk("t3_pending_kept", pending, 8'h82);
        ovf_clr = 8'h80;
        tick;
        ovf_clr = 8'h00;
        chk("t3_ovf_clr7", ovf, 8'h00);
        push(7, 1'b1); push(1, 1'b1);
        out_ready = 1'b1;
        repeat (4) tick;
        chk("t3_drained", out_valid, 0);

        // same-cycle load and new rise on ch4
        out_ready = 1'b0;
        push(4, 1'b1); push(4, 1'b1); push(4, 1'b1);
        evt_in = 8'h10;
        tick;
        tick;
        evt_in = 8'h00;
        tick;
        evt_in = 8'h10;
        tick;
        evt_in = 8'h00;
        tick;
        evt_in = 8'h10;
        out_ready = 1'b1;
        tick;
        chk("t4_pending_kept", pending, 8'h10);
        chk("t4_no_ovf", ovf, 8'h00);
        chk("t4_id", out_id, 4);
        tick;
        chk("t4_pending_clr", pending, 8'h00);
        tick;
        chk("t4_idle", out_valid, 0);
        evt_in = 8'h00;
        tick;

        // masked channel, then re-enable with input held high
        en_mask = 8'hBF;
        evt_in  = 8'h40;
        tick;
        tick;
        chk("t5_masked_pending", pending, 0);
        chk("t5_masked_valid", out_valid, 0);
        en_mask = 8'hFF;
        repeat (2) tick;
        chk("t5_reenable_pending", pending, 0);
        chk("t5_reenable_valid", out_valid, 0);
        evt_in = 8'h00;
        tick;

        // asynchronous reset mid-cycle with output busy and all pending
        out_ready = 1'b0;
        evt_in = 8'h01;
        tick;
        tick;
        evt_in = 8'h00;
        tick;
        evt_in = 8'hFF;
        tick;
        chk("t6_pending_all", pending, 8'hFF);
        chk("t6_valid", out_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_pending", pending, 0);
        chk("t6_async_ovf", ovf, 0);
        chk("t6_async_id", out_id, 0);
        evt_in = 8'h00;
        tick;
        tick;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick;
        chk("t6_quiet", out_valid, 0);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
